// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type and default parameters for parity_serial_tx
package parity_pkg;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/even_parity_gen.sv
// even_parity_gen: combinational even-parity bit (XOR of all data bits)
// ports: data (W bits) in, parity out; data plus parity always holds an even number of ones
module even_parity_gen
    import parity_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic [W-1:0] data,
    output logic         parity
);
    assign parity = ^data;
endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: serial transmitter framing a payload as start, data (LSB first), even parity, stop
// ports: clk, rst_n (async active-low); in_data/in_valid/in_ready payload handshake;
//        tx serial line (idle high); busy while framing; par_bit parity of last payload; done end-of-frame pulse
module parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              par_bit,
    output logic              done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              par_next;
    logic              wrap;

    even_parity_gen #(.W(DATA_W)) u_par (.data(in_data), .parity(par_next));

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign wrap     = cnt == LAST_CNT;

    // tx and done are registered, so each is loaded one cycle before the slot it belongs to;
    // done is raised on the cycle before the last STOP cycle, or on entry to STOP for one-cycle bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            par_bit <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (in_valid) begin
                    shreg   <= in_data;
                    par_bit <= par_next;
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: if (wrap) begin
                    tx    <= shreg[0];
                    shreg <= shreg >> 1;
                    state <= DATA;
                end
                DATA: if (wrap) begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        tx    <= par_bit;
                        state <= PARITY;
                    end else begin
                        idx   <= idx + 1'b1;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                PARITY: if (wrap) begin
                    tx    <= 1'b1;
                    state <= STOP;
                    done  <= CLKS_PER_BIT == 1;
                end
                STOP: if (wrap) state <= IDLE;
                      else done <= cnt == PRE_CNT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: randomized scoreboard bench for parity_serial_tx
`timescale 1ns/1ps
module tb_parity_serial_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int FL  = (DW + 3) * CPB;

    typedef struct {
        logic [DW-1:0] data;
        int            gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, tx, busy, par_bit, done;
    logic [DW-1:0] d1 = '0;
    logic          v1 = 1'b0;
    logic          rdy1, tx1, busy1, par1, done1;

    int   total = 0, bad = 0;
    int   cyc = 0, dones = 0, exp_dones = 0;
    exp_t q[$];
    exp_t cur;
    int   k = 0, end_cyc = -100;
    logic in_frame = 1'b0, last_par = 1'b0;

    always #5 clk = ~clk;

    parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .par_bit(par_bit), .done(done)
    );

    parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .par_bit(par1), .done(done1)
    );

    // reference frame: bit slot j of a frame carrying d
    function automatic logic frame_bit(input logic [DW-1:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= DW) return d[j-1];
        if (j == DW + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the expected frame when the DUT starts one and checks every cycle of it
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0;
            last_par = 1'b0;
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ready", in_ready, 1);
            chk("rst_par", par_bit, 0);
        end else begin
            if (!in_frame && busy) begin
                chk("frame_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    in_frame = 1'b1;
                    k = 0;
                    last_par = ^cur.data;
                    if (cur.gap > 0) chk("b2b_gap", cyc - end_cyc, cur.gap);
                end
            end
            if (in_frame) begin
                chk("tx_bit", tx, frame_bit(cur.data, k / CPB));
                chk("done_pos", done, k == FL - 1);
                chk("busy_in_frame", busy, 1);
                chk("ready_low", in_ready, 0);
                chk("par_bit", par_bit, last_par);
                if (done) dones++;
                if (k == FL - 1) begin
                    in_frame = 1'b0;
                    end_cyc = cyc;
                end
                k++;
            end else begin
                chk("idle_tx", tx, 1);
                chk("idle_done", done, 0);
                chk("idle_par", par_bit, last_par);
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input int gap);
        logic ok;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) begin
                q.push_back('{d, gap});
                exp_dones++;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stuck at %0b", in_ready);
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            if (q.size() == 0 && !in_frame && !busy) return;
            @(posedge clk); #1;
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: busy=%0b pending=%0d", busy, q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b, prev_b;
        repeat (3) @(negedge clk);
        chk("reset_ready", in_ready, 1);
        chk("reset_tx", tx, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        send(8'hA5, 0); in_valid = 1'b0; drain();
        chk("par_A5", par_bit, 0);
        send(8'h07, 0); in_valid = 1'b0; drain();
        chk("par_07", par_bit, 1);

        send(8'h00, 0);
        send(8'hFF, 2);
        in_valid = 1'b0;
        drain();
        chk("par_FF", par_bit, 0);

        send(8'h81, 0);
        in_valid = 1'b0;
        repeat (16) @(posedge clk); #1;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        chk("ignore_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        chk("par_81", par_bit, 0);

        send(8'h5A, 0);
        in_valid = 1'b0;
        repeat (19) @(posedge clk); #1;
        rst_n = 1'b0;
        exp_dones--;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h01, 0); in_valid = 1'b0; drain();
        chk("par_01", par_bit, 1);

        prev_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 1'($urandom_range(0, 1));
            send(DW'($urandom), prev_b ? 2 : 0);
            if (!b) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
            end
            prev_b = b;
        end
        in_valid = 1'b0;
        drain();
        chk("done_count", dones, exp_dones);

        d1 = 8'h5A;
        v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        for (int j = 0; j < DW + 3; j++) begin
            @(negedge clk);
            chk("cpb1_tx", tx1, frame_bit(8'h5A, j));
            chk("cpb1_done", done1, j == DW + 2);
            chk("cpb1_busy", busy1, 1);
        end
        @(negedge clk);
        chk("cpb1_end_busy", busy1, 0);
        chk("cpb1_end_done", done1, 0);
        chk("cpb1_par", par1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parity_serial_tx.md
PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits, legal range 2..16.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held, legal range 1..1024.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_data, input, DATA_W bits: payload to frame.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a payload.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port par_bit, output, 1 bit: even-parity bit of the last accepted payload.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL drive in_ready=1 only in IDLE; a transfer SHALL occur when in_valid && in_ready at a rising edge.
REQ-014 On transfer, SHALL capture in_data into a shift register, set par_bit = XOR-reduction of in_data (total ones in data+parity even), and enter START.
REQ-015 SHALL ignore in_valid outside IDLE; captured data SHALL NOT change mid-frame.
REQ-016 tx SHALL be registered: 1 in IDLE and STOP, 0 in START, current data bit in DATA (LSB first), par_bit in PARITY.
REQ-017 tx SHALL fall to 0 on the first cycle after the transfer edge (latency 1 cycle).
REQ-018 Each of START, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles; DATA SHALL last DATA_W*CLKS_PER_BIT cycles.
REQ-019 Frame length SHALL be (DATA_W+3)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-020 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit index SHALL count 0..DATA_W-1 and advance only on counter wrap.
REQ-021 done SHALL be 1 for exactly one cycle, the last STOP cycle; FSM SHALL then enter IDLE.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 Back-to-back: with in_valid held high, the next frame's START SHALL begin 2 cycles after the previous last STOP cycle (1 IDLE cycle for the transfer, then START).
REQ-024 CLKS_PER_BIT=1 SHALL give one cycle per bit with no counter stall.
REQ-025 par_bit SHALL hold its value until the next transfer.

Reset
REQ-026 While rst_n=0: state=IDLE, tx=1, in_ready=1 (combinational from state), busy=0, done=0, par_bit=0, counters=0, shift register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with no done pulse; after release the block SHALL accept a new payload.

Structure
REQ-028 State encoding typedef and the DATA_W/CLKS_PER_BIT defaults SHALL reside in shared package parity_pkg.
REQ-029 Parity computation SHALL be a combinational sub-module even_parity_gen (in: DATA_W data; out: parity bit), instantiated once.
REQ-030 Counter width SHALL be $clog2(CLKS_PER_BIT) bits, minimum 1.

Verification
REQ-031 DATA_W=8, CLKS_PER_BIT=4, in_data=8'hA5 -> par_bit=0; tx = 0, 1,0,1,0,0,1,0,1, 0, 1, each held 4 cycles; done at cycle 44.
REQ-032 in_data=8'h07 -> par_bit=1; parity-slot tx=1; total ones in data+parity = 4.
REQ-033 in_data=8'h00 then 8'hFF back-to-back, in_valid held high -> both par_bit=0; one IDLE cycle between frames; exactly two done pulses.
REQ-034 in_valid pulsed with 8'h3C during DATA of a frame carrying 8'h81 -> ignored; transmitted bits equal 8'h81; in_ready=0 throughout.
REQ-035 rst_n low for 1 cycle at frame cycle 20 -> tx=1 and busy=0 immediately, no done; a subsequent 8'h01 frame transmits correctly with par_bit=1.
REQ-036 CLKS_PER_BIT=1, in_data=8'h5A -> frame of 11 cycles, par_bit=0, done on cycle 11.
